// File: rtl/banded_counter.sv
// Up/down counter with load, wrap or saturate at the limits, and a registered
// classifier that maps the count onto equal-sized numbered bands 1..NUM_BANDS.
module banded_counter #(
  parameter int CNT_W     = 4,
  parameter int BAND_W    = 4,
  parameter int FIRST     = 1,
  parameter int BAND_SIZE = 3,
  parameter int NUM_BANDS = 3,
  parameter bit SAT       = 1'b0,
  parameter bit HOLD      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              dir,
  input  logic              load,
  input  logic [CNT_W-1:0]  load_val,
  output logic [CNT_W-1:0]  count,
  output logic [BAND_W-1:0] band,
  output logic              band_valid,
  output logic              band_chg,
  output logic              tc
);

  localparam longint LAST     = longint'(FIRST) + longint'(NUM_BANDS) * longint'(BAND_SIZE) - 1;
  localparam longint CNT_MAX  = (longint'(1) << CNT_W) - 1;
  localparam longint BAND_MAX = (longint'(1) << BAND_W) - 1;

  if (NUM_BANDS < 1 || BAND_SIZE < 1) begin : g_err_geometry
    $error("banded_counter: NUM_BANDS and BAND_SIZE must be at least 1");
  end
  if (longint'(NUM_BANDS) > BAND_MAX) begin : g_err_band_w
    $error("banded_counter: NUM_BANDS does not fit in BAND_W bits");
  end
  if (LAST > CNT_MAX) begin : g_err_range
    $error("banded_counter: top band extends past the counter range");
  end

  logic              at_max;
  logic              at_min;
  logic [63:0]       cnt_ext;
  logic              in_range;
  logic [BAND_W-1:0] band_idx;
  logic [BAND_W-1:0] band_nxt;
  logic              valid_nxt;

  assign at_max  = (count == '1);
  assign at_min  = (count == '0);
  assign tc      = dir ? at_max : at_min;
  assign cnt_ext = 64'(count);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      if (dir) begin
        if (!(SAT && at_max)) count <= count + CNT_W'(1);
      end else begin
        if (!(SAT && at_min)) count <= count - CNT_W'(1);
      end
    end
  end

  assign in_range = (cnt_ext >= 64'(FIRST)) && (cnt_ext <= 64'(LAST));

  // Each stage passes its own band number on once the count reaches its lower
  // bound, so the last stage holds the highest band whose bound is met.
  for (genvar i = 0; i < NUM_BANDS; i++) begin : g_chain
    logic [BAND_W-1:0] idx;
    if (i == 0) begin : g_first
      assign idx = BAND_W'(1);
    end else begin : g_next
      assign idx = (cnt_ext >= 64'(FIRST + i * BAND_SIZE)) ? BAND_W'(i + 1) : g_chain[i-1].idx;
    end
  end
  assign band_idx = g_chain[NUM_BANDS-1].idx;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    band_nxt  = HOLD ? band : '0;
    valid_nxt = 1'b0;
    if (in_range) begin
      band_nxt  = band_idx;
      valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      band       <= '0;
      band_valid <= 1'b0;
      band_chg   <= 1'b0;
    end else begin
      band       <= band_nxt;
      band_valid <= valid_nxt;
      band_chg   <= (band_nxt != band);
    end
  end

endmodule
